// File: rtl/stack_pkg.sv
// Shared definitions for the memory-resident stack controller and SP register users.
package stack_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RWAIT,
        S_DONE
    } state_t;

    localparam int unsigned STACK_TOP_DEFAULT  = 64;
    localparam int unsigned STACK_BASE_DEFAULT = 0;

endpackage

// File: rtl/sp_counter.sv
// Stack pointer register: counts down on push, up on pop; TOP means empty, BASE means full.
module sp_counter
    import stack_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STACK_TOP  = STACK_TOP_DEFAULT,
    parameter int unsigned STACK_BASE = STACK_BASE_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inc,
    input  logic              dec,
    output logic [ADDR_W-1:0] count,
    output logic              empty,
    output logic              full
);

    localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(STACK_TOP);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(STACK_BASE);
    localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= TOP;
        end else if (dec) begin
            count <= count - ONE;
        end else if (inc) begin
            count <= count + ONE;
        end
    end

    assign empty = (count == TOP);
    assign full  = (count == BASE);

endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencer for the memory-resident stack; drives the shared synchronous memory port.
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned STACK_TOP  = STACK_TOP_DEFAULT,
    parameter int unsigned STACK_BASE = STACK_BASE_DEFAULT
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Push,
    input  logic              Pop,
    input  logic [DATA_W-1:0] DIn,
    output logic [DATA_W-1:0] DOut,
    output logic              Done,
    output logic              Err,
    output logic              Busy,
    output logic              Empty,
    output logic              Full,
    output logic [ADDR_W-1:0] SP,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWr,
    input  logic [DATA_W-1:0] MemRData
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    state_t            state, state_nxt;
    logic              err_q, err_nxt;
    logic [DATA_W-1:0] wdata;

    sp_counter #(
        .ADDR_W    (ADDR_W),
        .STACK_TOP (STACK_TOP),
        .STACK_BASE(STACK_BASE)
    ) u_sp (
        .clk   (Clock),
        .resetn(Resetn),
        .inc   (state == S_RWAIT),
        .dec   (state == S_WRITE),
        .count (SP),
        .empty (Empty),
        .full  (Full)
    );

    always_comb begin
        state_nxt = state;
        err_nxt   = err_q;
        case (state)
            S_IDLE: begin
                if (Push && Pop) begin
                    state_nxt = S_DONE;
                    err_nxt   = 1'b1;
                end else if (Push) begin
                    state_nxt = Full ? S_DONE : S_WRITE;
                    err_nxt   = Full;
                end else if (Pop) begin
                    state_nxt = Empty ? S_DONE : S_READ;
                    err_nxt   = Empty;
                end
            end
            S_WRITE: state_nxt = S_DONE;
            S_READ:  state_nxt = S_RWAIT;
            S_RWAIT: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state <= S_IDLE;
            err_q <= 1'b0;
            wdata <= '0;
            DOut  <= '0;
        end else begin
            state <= state_nxt;
            err_q <= err_nxt;
            if (state == S_IDLE && Push) begin
                wdata <= DIn;
            end
            // Read data arrives one cycle after the address was first presented in READ
            if (state == S_RWAIT) begin
                DOut <= MemRData;
            end
        end
    end

    assign Busy     = (state != S_IDLE);
    assign Done     = (state == S_DONE);
    assign Err      = Done && err_q;
    assign MemWr    = (state == S_WRITE);
    assign MemAddr  = (state == S_WRITE) ? (SP - ONE) : SP;
    assign MemWData = wdata;

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: driver queues expected completions and writes, monitors compare.
module tb_stack_ctrl;

    logic        Clock;
    logic        Resetn;
    logic        Push;
    logic        Pop;
    logic [15:0] DIn;
    logic [15:0] DOut;
    logic        Done;
    logic        Err;
    logic        Busy;
    logic        Empty;
    logic        Full;
    logic [15:0] SP;
    logic [15:0] MemAddr;
    logic [15:0] MemWData;
    logic        MemWr;
    logic [15:0] MemRData;

    stack_ctrl #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .STACK_TOP (64),
        .STACK_BASE(0)
    ) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Push    (Push),
        .Pop     (Pop),
        .DIn     (DIn),
        .DOut    (DOut),
        .Done    (Done),
        .Err     (Err),
        .Busy    (Busy),
        .Empty   (Empty),
        .Full    (Full),
        .SP      (SP),
        .MemAddr (MemAddr),
        .MemWData(MemWData),
        .MemWr   (MemWr),
        .MemRData(MemRData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Synchronous data memory: read data valid one cycle after the address
    logic [15:0] mem [0:65535];
    always @(posedge Clock) begin
        if (MemWr) mem[MemAddr] <= MemWData;
        MemRData <= mem[MemAddr];
    end

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        logic        err;
        logic [15:0] dout;
        logic [15:0] sp;
        int unsigned cyc;
    } done_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int unsigned cyc;
    } wr_t;

    done_t done_q[$];
    wr_t   wr_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    done_t md;
    wr_t   mw;
    always @(negedge Clock) begin
        check("err_only_with_done", 32'(Err & ~Done), 32'd0);
        if (Done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                md = done_q.pop_front();
                check("done_err", 32'(Err), 32'(md.err));
                check("done_dout", 32'(DOut), 32'(md.dout));
                check("done_sp", 32'(SP), 32'(md.sp));
                check("done_cycle", cyc, md.cyc);
            end
        end
        if (MemWr) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", 32'(MemAddr), 32'hFFFF_FFFF);
            end else begin
                mw = wr_q.pop_front();
                check("wr_addr", 32'(MemAddr), 32'(mw.addr));
                check("wr_data", 32'(MemWData), 32'(mw.data));
                check("wr_cycle", cyc, mw.cyc);
            end
        end
    end

    // Reference model of the stack
    int unsigned msp = 64;
    logic [15:0] mmem [0:63];
    logic [15:0] mdout = 16'h0000;

    // Issue one request at the current negedge; optionally spray requests while busy
    task automatic req(input logic p, input logic q, input logic [15:0] din, input logic noise);
        int unsigned lat;
        done_t d;
        wr_t   w;
        Push = p;
        Pop  = q;
        DIn  = din;
        d.err = 1'b0;
        if (p && q) begin
            d.err = 1'b1;
            lat = 1;
        end else if (p) begin
            if (msp == 0) begin
                d.err = 1'b1;
                lat = 1;
            end else begin
                msp = msp - 1;
                mmem[msp] = din;
                w.addr = 16'(msp);
                w.data = din;
                w.cyc  = cyc + 1;
                wr_q.push_back(w);
                lat = 2;
            end
        end else begin
            if (msp == 64) begin
                d.err = 1'b1;
                lat = 1;
            end else begin
                mdout = mmem[msp];
                msp = msp + 1;
                lat = 3;
            end
        end
        d.dout = mdout;
        d.sp   = 16'(msp);
        d.cyc  = cyc + lat;
        done_q.push_back(d);
        for (int i = 0; i < int'(lat); i++) begin
            @(negedge Clock);
            Push = noise;
            Pop  = noise;
            DIn  = 16'h5A5A;
        end
        @(negedge Clock);
        Push = 1'b0;
        Pop  = 1'b0;
    endtask

    task automatic do_reset();
        Resetn = 1'b0;
        @(negedge Clock);
        Resetn = 1'b1;
        msp   = 64;
        mdout = 16'h0000;
    endtask

    initial begin
        Resetn = 1'b0;
        Push   = 1'b0;
        Pop    = 1'b0;
        DIn    = 16'h0000;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        check("rst_sp", 32'(SP), 32'd64);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_done", 32'(Done), 32'd0);
        check("rst_err", 32'(Err), 32'd0);
        check("rst_memwr", 32'(MemWr), 32'd0);
        check("rst_dout", 32'(DOut), 32'd0);

        req(1'b1, 1'b0, 16'hBEEF, 1'b0);
        check("push1_empty", 32'(Empty), 32'd0);
        check("push1_sp", 32'(SP), 32'd63);
        req(1'b0, 1'b1, 16'h0000, 1'b0);

        req(1'b1, 1'b0, 16'h1111, 1'b0);
        req(1'b1, 1'b0, 16'h2222, 1'b0);
        req(1'b0, 1'b1, 16'h0000, 1'b0);
        req(1'b0, 1'b1, 16'h0000, 1'b0);
        check("lifo_empty", 32'(Empty), 32'd1);

        req(1'b0, 1'b1, 16'h0000, 1'b0);
        check("underflow_sp", 32'(SP), 32'd64);

        req(1'b1, 1'b1, 16'h3333, 1'b0);
        req(1'b1, 1'b0, 16'h4444, 1'b1);
        req(1'b1, 1'b1, 16'h3535, 1'b1);
        req(1'b0, 1'b1, 16'h0000, 1'b1);
        check("busy_ignore_sp", 32'(SP), 32'd64);

        for (int i = 0; i < 64; i++) req(1'b1, 1'b0, 16'(16'h1000 + i), 1'b0);
        check("full_flag", 32'(Full), 32'd1);
        check("full_sp", 32'(SP), 32'd0);
        req(1'b1, 1'b0, 16'hAAAA, 1'b0);
        check("overflow_sp", 32'(SP), 32'd0);
        req(1'b0, 1'b1, 16'h0000, 1'b0);

        do_reset();
        req(1'b1, 1'b0, 16'hC001, 1'b0);
        req(1'b1, 1'b0, 16'hC002, 1'b0);
        check("pre_abort_sp", 32'(SP), 32'd62);
        Pop = 1'b1;
        @(negedge Clock);
        Pop = 1'b0;
        @(negedge Clock);
        check("abort_busy", 32'(Busy), 32'd1);
        Resetn = 1'b0;
        @(negedge Clock);
        check("abort_sp", 32'(SP), 32'd64);
        check("abort_busy_after", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_dout", 32'(DOut), 32'd0);
        Resetn = 1'b1;
        msp   = 64;
        mdout = 16'h0000;

        req(1'b1, 1'b0, 16'h7777, 1'b0);
        req(1'b0, 1'b1, 16'h0000, 1'b0);

        repeat (3) @(negedge Clock);
        check("pending_done", 32'(done_q.size()), 32'd0);
        check("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Stack controller for the processor's memory-resident stack: accepts single-word push/pop requests from the control unit, sequences the memory write or read, and owns the stack pointer. It is the consumer side of the stack-pointer register. It decrements the pointer on push and increments it on pop, so the top-of-memory reset value (64) means "empty". It sits between the control FSM and the shared synchronous data memory port.

## Interface
Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, memory address / SP width
- STACK_TOP, 64, SP reset value; SP == STACK_TOP means empty
- STACK_BASE, 0, lowest usable address; SP == STACK_BASE means full

Ports:
- Clock  in  1  single clock; all state updates on the rising edge
- Resetn  in  1  synchronous, active-low reset
- Push  in  1  push request, sampled only in IDLE
- Pop  in  1  pop request, sampled only in IDLE
- DIn  in  DATA_W  word to push, sampled with Push
- DOut  out  DATA_W  last popped word, held until the next successful pop
- Done  out  1  one-cycle completion pulse
- Err  out  1  overflow/underflow/conflict flag, valid only with Done
- Busy  out  1  high whenever state != IDLE
- Empty  out  1  SP == STACK_TOP (combinational)
- Full  out  1  SP == STACK_BASE (combinational)
- SP  out  ADDR_W  current stack pointer
- MemAddr  out  ADDR_W  memory address
- MemWData  out  DATA_W  memory write data
- MemWr  out  1  memory write enable
- MemRData  in  DATA_W  memory read data, valid one cycle after MemAddr is presented

## Operation
- Requests are sampled only in IDLE. While Busy is high, requests are ignored and not queued.
- States: IDLE, WRITE, READ, RWAIT, DONE.
- IDLE:
  - Push & !Pop & !Full: latch DIn, go to WRITE.
  - Pop & !Push & !Empty: go to READ.
  - Push & Pop: conflict. Go to DONE with Err set.
  - Push & Full (overflow) or Pop & Empty (underflow): go to DONE with Err set.
  - SP is unchanged on every error path.
- WRITE:
  - MemAddr = SP-1, MemWData = latched word, MemWr = 1.
  - SP <= SP-1.
  - Go to DONE.
- READ:
  - MemAddr = SP, MemWr = 0.
  - Go to RWAIT.
- RWAIT:
  - MemAddr held at SP.
  - DOut <= MemRData; SP <= SP+1.
  - Go to DONE.
- DONE:
  - Done = 1; Err = 1 if the error path was taken.
  - Go to IDLE.
- MemWr is 1 only in WRITE. MemAddr = SP in all other states.
- SP arithmetic is ADDR_W-bit unsigned. The Full/Empty checks prevent wrap, so SP never leaves [STACK_BASE, STACK_TOP].

## Timing
- Reset values, applied on the first rising edge with Resetn = 0:
  - state = IDLE, SP = STACK_TOP (64).
  - DOut = 0, Done = 0, Err = 0, MemWr = 0, Busy = 0.
  - Empty = 1, Full = 0.
- Reset mid-operation abandons the transaction at the next edge, with no partial SP update. A write already issued in WRITE stays in memory.
- Push latency: request edge N -> WRITE in cycle N+1 -> Done in cycle N+2. Next request is accepted at edge N+3.
- Pop latency: request edge N -> READ N+1 -> RWAIT N+2 -> Done N+3. DOut and SP are updated at the start of N+3.
- Error latency: Done and Err both high in cycle N+1.
- Done and Err never assert outside the DONE state.

## Structure
- Shared package stack_pkg holds:
  - state enum encoding for IDLE, WRITE, READ, RWAIT, DONE
  - STACK_TOP_DEFAULT = 64 and STACK_BASE_DEFAULT = 0, shared with the SP register users
- One sub-module, sp_counter:
  - ADDR_W-bit register with synchronous active-low reset to STACK_TOP
  - inputs inc and dec, mutually exclusive
  - outputs the count and the Empty/Full compares
- FSM and datapath latches live in stack_ctrl.

## Test plan
- Reset, then push 0xBEEF -> MemWr = 1 with MemAddr = 63 and MemWData = 0xBEEF in cycle 1; Done in cycle 2; SP = 63; Empty = 0.
- Push 0x1111, push 0x2222, pop, pop -> DOut = 0x2222 then 0x1111; SP sequence 63, 62, 63, 64; Empty = 1 at end.
- Pop from empty (SP = 64) -> Done = Err = 1 one cycle after the request; SP = 64; MemWr never asserted.
- Push 64 words to reach Full, then push 0xAAAA -> Err = 1; SP stays 0; no write to any address.
- Push and Pop asserted together in IDLE -> Done = Err = 1; SP unchanged. Requests pulsed while Busy are ignored (SP changes exactly once).
- Resetn low during RWAIT of a pop at SP = 62 -> next cycle SP = 64, state IDLE, Done = 0, DOut = 0.
